dc_video_capture: RTL and testbench

- Front-end capture stage; sits directly upstream of the video-to-RAM write stage.
- Receives the raw Dreamcast 12-bit digital video bus, two clocks per pixel, with active-low HSYNC/VSYNC.
- Assembles 24-bit RGB pixels and maintains the pixel/line counters consumed downstream.
- Classifies the incoming mode (progressive vs interlaced, NTSC vs PAL) and drives line_doubler and is_pal.

---
 rtl/dc_video_capture.sv | 133 +++++++++++++
 tb/tb_dc_video_capture.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_video_capture.sv
// Front-end capture for the Dreamcast 12-bit video bus: assembles 24-bit RGB from two
// bus words per pixel, tracks pixel/line position and classifies the incoming video mode.
module dc_video_capture #(
   parameter int PROG_LINE_MIN = 400,
   parameter int PAL_LINE_MIN  = 300,
   parameter int MODE_CONFIRM  = 2
) (
   input  logic        clock,
   input  logic        nreset,
   input  logic [11:0] data,
   input  logic        _hsync,
   input  logic        _vsync,
   output logic [7:0]  R,
   output logic [7:0]  G,
   output logic [7:0]  B,
   output logic [11:0] counterX,
   output logic [11:0] counterY,
   output logic        line_doubler,
   output logic        is_pal
);

   localparam int CW = $clog2(MODE_CONFIRM + 1);
   localparam logic [11:0] PROG_MIN = 12'(PROG_LINE_MIN);
   localparam logic [11:0] PAL_MIN  = 12'(PAL_LINE_MIN);
   localparam logic [CW-1:0] CONFIRM_MAX = CW'(MODE_CONFIRM);

   typedef enum logic [1:0] {
      MODE_PROG   = 2'd0,
      MODE_NTSC_I = 2'd1,
      MODE_PAL_I  = 2'd2
   } mode_t;

   logic          hs_q, hs_prev, vs_q, vs_prev;
   logic          hs_fall, vs_fall;
   logic          phase;
   logic          locked;
   logic [11:0]   lo;
   mode_t         cand_mode;
   mode_t         cls_mode;
   logic [CW-1:0] confirm_cnt;
   logic [CW-1:0] next_cnt;
   logic          apply_mode;

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         hs_q    <= 1'b1;
         hs_prev <= 1'b1;
         vs_q    <= 1'b1;
         vs_prev <= 1'b1;
      end else begin
         hs_q    <= _hsync;
         hs_prev <= hs_q;
         vs_q    <= _vsync;
         vs_prev <= vs_q;
      end
   end

   assign hs_fall = hs_prev & ~hs_q;
   assign vs_fall = vs_prev & ~vs_q;

   // Pixels are only trusted once an HSYNC edge has aligned the two-word phase.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         phase    <= 1'b0;
         locked   <= 1'b0;
         lo       <= '0;
         R        <= '0;
         G        <= '0;
         B        <= '0;
         counterX <= '0;
      end else if (hs_fall) begin
         phase    <= 1'b0;
         locked   <= 1'b1;
         counterX <= '0;
      end else begin
         phase <= ~phase;
         if (!phase) begin
            lo <= data;
         end else if (locked) begin
            R <= lo[11:4];
            G <= {lo[3:0], data[11:8]};
            B <= data[7:0];
            if (counterX != 12'hFFF) begin
               counterX <= counterX + 12'd1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         counterY <= '0;
      end else if (vs_fall) begin
         counterY <= '0;
      end else if (hs_fall && counterY != 12'hFFF) begin
         counterY <= counterY + 12'd1;
      end
   end

   always_comb begin
      cls_mode = MODE_PROG;
      if (counterY < PROG_MIN) begin
         cls_mode = (counterY >= PAL_MIN) ? MODE_PAL_I : MODE_NTSC_I;
      end
      next_cnt = CW'(1);
      if (cls_mode == cand_mode) begin
         next_cnt = (confirm_cnt < CONFIRM_MAX) ? confirm_cnt + CW'(1) : confirm_cnt;
      end
   end

   // Mode outputs move only after MODE_CONFIRM identical field classifications in a row.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         cand_mode    <= MODE_PROG;
         confirm_cnt  <= '0;
         apply_mode   <= 1'b0;
         line_doubler <= 1'b0;
         is_pal       <= 1'b0;
      end else begin
         apply_mode <= 1'b0;
         if (vs_fall) begin
            cand_mode   <= cls_mode;
            confirm_cnt <= next_cnt;
            apply_mode  <= (next_cnt == CONFIRM_MAX);
         end
         if (apply_mode) begin
            line_doubler <= (cand_mode != MODE_PROG);
            is_pal       <= (cand_mode == MODE_PAL_I);
         end
      end
   end

endmodule

// File: tb/tb_dc_video_capture.sv
// Bench for dc_video_capture: a timing-level reference model compared every cycle,
// plus directed checks with hand-computed values at the interesting points.
module tb_dc_video_capture;

   localparam int PROG_MIN = 400;
   localparam int PAL_MIN  = 300;

   logic        clock;
   logic        nreset;
   logic [11:0] videoData;
   logic        hsyncN;
   logic        vsyncN;
   logic [7:0]  R, G, B;
   logic [11:0] counterX, counterY;
   logic        lineDoubler, isPal;

   int checkCount = 0;
   int passCount  = 0;
   int patSeed    = 0;

   dc_video_capture dut (
      .clock        (clock),
      .nreset       (nreset),
      .data         (videoData),
      ._hsync       (hsyncN),
      ._vsync       (vsyncN),
      .R            (R),
      .G            (G),
      .B            (B),
      .counterX     (counterX),
      .counterY     (counterY),
      .line_doubler (lineDoubler),
      .is_pal       (isPal)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference model state: input sample history and expected outputs.
   logic        mH1, mH2, mV1, mV2;
   logic        mLocked;
   int          mPos;
   logic [11:0] mPrevData;
   logic [7:0]  expR, expG, expB;
   int          expX, expY;
   logic [1:0]  clsHist[$];
   logic        mPending;
   logic [1:0]  mPendCls;
   logic        expLd, expPal;

   task automatic resetModel();
      mH1 = 1'b1; mH2 = 1'b1; mV1 = 1'b1; mV2 = 1'b1;
      mLocked = 1'b0; mPos = 0; mPrevData = '0;
      expR = '0; expG = '0; expB = '0; expX = 0; expY = 0;
      clsHist.delete();
      mPending = 1'b0; mPendCls = '0; expLd = 1'b0; expPal = 1'b0;
   endtask

   task automatic stepModel();
      logic hsFall, vsFall;
      logic [1:0] c;
      hsFall = mH2 && !mH1;
      vsFall = mV2 && !mV1;
      if (mPending) begin
         expLd = mPendCls[1];
         expPal = mPendCls[0];
         mPending = 1'b0;
      end
      if (vsFall) begin
         c[1] = (expY < PROG_MIN);
         c[0] = c[1] && (expY >= PAL_MIN);
         clsHist.push_back(c);
         if (clsHist.size() > 2) void'(clsHist.pop_front());
         if (clsHist.size() == 2 && clsHist[0] == clsHist[1]) begin
            mPending = 1'b1;
            mPendCls = c;
         end
         expY = 0;
      end else if (hsFall && expY < 4095) begin
         expY++;
      end
      if (hsFall) begin
         mLocked = 1'b1;
         mPos = 0;
         expX = 0;
      end else if (mLocked) begin
         mPos++;
         if (mPos % 2 == 0) begin
            expX = (mPos / 2 > 4095) ? 4095 : mPos / 2;
            expR = mPrevData[11:4];
            expG = {mPrevData[3:0], videoData[11:8]};
            expB = videoData[7:0];
         end
      end
      mPrevData = videoData;
      mH2 = mH1; mH1 = hsyncN;
      mV2 = mV1; mV1 = vsyncN;
   endtask

   initial begin : model
      resetModel();
      forever begin
         @(posedge clock or negedge nreset);
         if (!nreset) resetModel();
         else stepModel();
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
   endtask

   initial begin : compare
      forever begin
         @(negedge clock);
         checkOutput("cycle",
            64'({R, G, B, counterX, counterY, lineDoubler, isPal}),
            64'({expR, expG, expB, 12'(expX), 12'(expY), expLd, expPal}));
      end
   end

   task automatic applyStimulus(input logic hs, input logic vs, input logic [11:0] d);
      @(negedge clock);
      hsyncN = hs;
      vsyncN = vs;
      videoData = d;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b1, 1'b1, videoData);
   endtask

   task automatic doLine(input int nclk);
      for (int i = 0; i < nclk; i++) begin
         applyStimulus((i == 0) ? 1'b0 : 1'b1, 1'b1, 12'(patSeed + i * 317));
      end
      patSeed += 97;
   endtask

   task automatic doVsync();
      applyStimulus(1'b1, 1'b0, videoData);
      applyStimulus(1'b1, 1'b1, videoData);
   endtask

   task automatic doField(input int nLines);
      repeat (nLines) doLine(4);
      doVsync();
      idle(3);
   endtask

   task automatic checkMode(input string name, input logic ld, input logic pal);
      checkOutput({name, "_ld"}, 64'(lineDoubler), 64'(ld));
      checkOutput({name, "_pal"}, 64'(isPal), 64'(pal));
   endtask

   initial begin : stimulus
      hsyncN = 1'b1;
      vsyncN = 1'b1;
      videoData = '0;
      nreset = 1'b1;
      #1 nreset = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("reset_rgb", 64'({R, G, B}), 64'(0));
      checkOutput("reset_xy", 64'({counterX, counterY}), 64'(0));
      checkMode("reset", 1'b0, 1'b0);
      nreset = 1'b1;
      idle(4);

      // First pixel after an HSYNC edge
      applyStimulus(1'b0, 1'b1, 12'h000);
      applyStimulus(1'b1, 1'b1, 12'h000);
      applyStimulus(1'b1, 1'b1, 12'hABC);
      applyStimulus(1'b1, 1'b1, 12'hDEF);
      @(negedge clock);
      checkOutput("pix_R", 64'(R), 64'(8'hAB));
      checkOutput("pix_G", 64'(G), 64'(8'hCD));
      checkOutput("pix_B", 64'(B), 64'(8'hEF));
      checkOutput("pix_X", 64'(counterX), 64'(1));
      checkOutput("pix_Y", 64'(counterY), 64'(1));

      // Full 858-pixel lines
      doLine(1716);
      @(negedge clock);
      checkOutput("line1_X", 64'(counterX), 64'(857));
      checkOutput("line1_Y", 64'(counterY), 64'(2));
      doLine(1716);
      @(negedge clock);
      checkOutput("line2_X", 64'(counterX), 64'(857));
      checkOutput("line2_Y", 64'(counterY), 64'(3));
      doVsync();
      idle(2);
      checkOutput("vs_clear_Y", 64'(counterY), 64'(0));

      // Mode sequence: progressive, NTSC interlaced, PAL interlaced
      repeat (3) doField(525);
      checkMode("prog", 1'b0, 1'b0);
      doField(262);
      checkMode("ntsc1", 1'b0, 1'b0);
      doField(263);
      checkMode("ntsc2", 1'b1, 1'b0);
      doField(312);
      checkMode("pal1", 1'b1, 1'b0);
      doField(313);
      checkMode("pal2", 1'b1, 1'b1);

      // Single progressive glitch inside stable NTSC interlaced
      doField(262);
      doField(263);
      checkMode("ntsc_again", 1'b1, 1'b0);
      doField(525);
      checkMode("glitch", 1'b1, 1'b0);
      doField(263);
      checkMode("glitch_after1", 1'b1, 1'b0);
      doField(263);
      checkMode("glitch_after2", 1'b1, 1'b0);

      // Classification thresholds
      doField(400);
      doField(400);
      checkMode("l400", 1'b0, 1'b0);
      doField(399);
      doField(399);
      checkMode("l399", 1'b1, 1'b1);
      doField(299);
      doField(299);
      checkMode("l299", 1'b1, 1'b0);
      doField(300);
      doField(300);
      checkMode("l300", 1'b1, 1'b1);

      // HSYNC and VSYNC falling together
      repeat (5) doLine(4);
      applyStimulus(1'b0, 1'b0, videoData);
      applyStimulus(1'b1, 1'b1, videoData);
      @(negedge clock);
      checkOutput("both_X", 64'(counterX), 64'(0));
      checkOutput("both_Y", 64'(counterY), 64'(0));

      // Saturation of both counters
      doLine(8200);
      @(negedge clock);
      checkOutput("sat_X", 64'(counterX), 64'(4095));
      repeat (4100) doLine(4);
      @(negedge clock);
      checkOutput("sat_Y", 64'(counterY), 64'(4095));

      // Reset in the middle of a line
      doVsync();
      repeat (100) doLine(4);
      idle(2);
      checkOutput("pre_reset_Y", 64'(counterY), 64'(100));
      checkOutput("pre_reset_ld", 64'(lineDoubler), 64'(1));
      #2 nreset = 1'b0;
      #1;
      checkOutput("midreset_rgb", 64'({R, G, B}), 64'(0));
      checkOutput("midreset_xy", 64'({counterX, counterY}), 64'(0));
      checkMode("midreset", 1'b0, 1'b0);
      @(negedge clock);
      nreset = 1'b1;
      doField(263);
      checkMode("post_reset1", 1'b0, 1'b0);
      doField(263);
      checkMode("post_reset2", 1'b1, 1'b0);

      idle(4);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
